// File: rtl/dmem_port_arbiter.sv
// Serialises one write plus up to NRD reads onto a single-port RAM, write first, then reads in port order.
// Stall lasts 1+W+R cycles, plus one drain cycle when R>0; done pulses next. Inputs are ignored from snapshot to DONE.
module dmem_port_arbiter #(
  parameter int AW  = 14,
  parameter int DW  = 10,
  parameter int NRD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD-1:0]    rd_req,
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic              wr_req,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  output logic              stall,
  output logic              done,
  output logic [NRD-1:0]    rd_valid,
  output logic [NRD*DW-1:0] rd_data,
  output logic              ram_we,
  output logic [AW-1:0]     ram_addr,
  output logic [DW-1:0]     ram_wdata,
  input  logic [DW-1:0]     ram_rdata
);

  localparam int IW = (NRD > 1) ? $clog2(NRD) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [NRD-1:0]    rd_mask;
    logic [NRD*AW-1:0] rd_addr;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
  } snap_t;

  state_t        state;
  logic [NRD:0]  pend;
  logic [NRD:0]  after_issue;
  logic [NRD:0]  nx_mask;
  logic [IW-1:0] cur_idx;
  logic [IW-1:0] nx_idx;
  logic [IW-1:0] cap_idx;
  logic          cap_vld;
  logic          any_req;
  logic          issue_next;
  logic          finish_next;
  snap_t         snap;
  snap_t         live;
  snap_t         src;
  logic [AW-1:0] nx_ram_addr;
  logic [DW-1:0] nx_ram_wdata;

  assign any_req = (|rd_req) | wr_req;
  assign stall   = rst && ((state == IDLE) ? any_req : (state == ISSUE || state == DRAIN));

  // The RAM port is registered, so the op for the coming cycle is picked one edge early:
  // from the live requests in IDLE, or from what is still pending after the current issue.
  always_comb begin
    live.rd_mask = rd_req;
    live.rd_addr = rd_addr;
    live.wr_addr = wr_addr;
    live.wr_data = wr_data;

    cur_idx = '0;
    for (int k = NRD - 1; k >= 0; k--)
      if (pend[k]) cur_idx = IW'(k);
    after_issue = pend;
    if (pend[NRD]) after_issue[NRD] = 1'b0;
    else           after_issue[cur_idx] = 1'b0;

    if (state == IDLE) begin
      nx_mask    = {wr_req, rd_req};
      src        = live;
      issue_next = any_req;
    end else begin
      nx_mask    = after_issue;
      src        = snap;
      issue_next = (state == ISSUE) && (|after_issue);
    end

    nx_idx = '0;
    for (int k = NRD - 1; k >= 0; k--)
      if (nx_mask[k]) nx_idx = IW'(k);
    nx_ram_addr  = nx_mask[NRD] ? src.wr_addr : src.rd_addr[int'(nx_idx)*AW +: AW];
    nx_ram_wdata = nx_mask[NRD] ? src.wr_data : '0;

    finish_next = (state == DRAIN) ||
                  ((state == ISSUE) && !(|after_issue) && pend[NRD]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pend      <= '0;
      snap      <= '0;
      cap_vld   <= 1'b0;
      cap_idx   <= '0;
      rd_data   <= '0;
      done      <= 1'b0;
      rd_valid  <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we    <= issue_next && nx_mask[NRD];
      ram_addr  <= issue_next ? nx_ram_addr  : '0;
      ram_wdata <= issue_next ? nx_ram_wdata : '0;

      // RAM data trails its address by one cycle, so captures run one cycle behind issue.
      cap_vld <= (state == ISSUE) && !pend[NRD];
      cap_idx <= cur_idx;
      if (cap_vld) rd_data[int'(cap_idx)*DW +: DW] <= ram_rdata;

      done     <= finish_next;
      rd_valid <= finish_next ? snap.rd_mask : '0;

      case (state)
        IDLE: begin
          if (any_req) begin
            state <= ISSUE;
            pend  <= {wr_req, rd_req};
            snap  <= live;
          end
        end
        ISSUE: begin
          pend <= after_issue;
          if (!(|after_issue)) state <= pend[NRD] ? DONE : DRAIN;
        end
        DRAIN:   state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares one single-port synchronous data RAM among the pipeline's four read requesters and one write requester. In one cycle, the pipeline can raise D_READ1..4 together with D_WRITE. The arbiter snapshots that set of requests and stalls the pipeline. It then replays the operations one per cycle on the RAM port: the write first, then reads in port order. Finally it returns per-port read data and releases the stall.

Parameters:
AW, 14, address width
DW, 10, data width
NRD, 4, number of read ports

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
rd_req  in  NRD  read request, bit k for port k
rd_addr  in  NRD*AW  port k address at [k*AW +: AW]
wr_req  in  1  write request
wr_addr  in  AW  write address
wr_data  in  DW  write data
stall  out  1  pipeline hold
done  out  1  one-cycle pulse; batch complete
rd_valid  out  NRD  one-cycle pulse, with done, for each port served
rd_data  out  NRD*DW  port k data at [k*DW +: DW]; holds until recaptured
ram_we  out  1  RAM write enable
ram_addr  out  AW  RAM address
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data, valid one cycle after its address

Behaviour:
- States: IDLE, ISSUE, DRAIN, DONE.
- Reset (rst low): state IDLE; pending mask, snapshot registers and rd_data cleared. stall, done, rd_valid, ram_we, ram_addr and ram_wdata are all 0. stall is forced 0 while rst is low.
- IDLE:
  - stall = |rd_req | wr_req, combinational.
  - If any request is present, at the clock edge: snapshot the pending mask {wr_req, rd_req}, all addresses and wr_data, then go to ISSUE.
  - No RAM access is made in IDLE.
- ISSUE, one operation per cycle, priority order: write, rd0, rd1, rd2, rd3.
  - Write: ram_we=1, ram_addr=snapshot wr_addr, ram_wdata=snapshot wr_data.
  - Read k: ram_we=0, ram_addr=snapshot addr k.
  - The issued op's pending bit is cleared at the edge.
  - When the issued op is the last pending one: go to DRAIN if it was a read, else go to DONE.
- Read capture: a read of port k issued in cycle t is captured from ram_rdata into rd_data[k] at the edge ending cycle t+1.
  - This capture overlaps with the next ISSUE or with DRAIN.
  - A per-cycle "capture index" register records which port to load.
- DRAIN: captures the final read, then goes to DONE.
- stall = 1 in ISSUE and DRAIN, and 0 in DONE.
- DONE:
  - done=1; rd_valid = snapshot rd mask.
  - Always go to IDLE next.
  - Live requests during DONE are ignored; the pipeline advances on this cycle.
- RAM outputs are 0 when not issuing.
- Latency for a batch of W writes (0/1) and R reads:
  - stall cycles = 1 + W + R + (R>0 ? 1 : 0).
  - done asserts in the following cycle.
- Ordering: a read of the same address as the batch write returns the new data, because the write is issued first.
- Ports with no request keep their old rd_data and get rd_valid=0.
- Input changes after the snapshot have no effect until the next IDLE.
- Reset mid-batch returns immediately to IDLE. The batch is discarded, with no done or rd_valid pulse and no further RAM access.

Test Plan:
- Idle: no requests for 10 cycles -> stall, done, ram_we all 0; ram_addr 0.
- Single read:
  - Setup: RAM[0x0010]=0x155; rd_req=0001, addr0=0x0010.
  - Required response: stall high for 3 cycles; ram_addr=0x0010 in cycle 2; done and rd_valid=0001 in cycle 4; rd_data[0]=0x155.
- Write then read of the same address:
  - Setup: wr 0x0020<-0x2AA; rd_req=0100, addr2=0x0020.
  - Required response: ram_we=1 in cycle 2, read issued in cycle 3; stall 4 cycles; rd_data[2]=0x2AA.
- Full batch:
  - Setup: write plus 4 reads, RAM[0x100..0x103]=1,2,3,4.
  - Required response: issue order W,r0,r1,r2,r3; stall 7 cycles; rd_valid=1111; rd_data = 1,2,3,4.
- Requests held in DONE: keep rd_req=0001 asserted through DONE -> no re-issue in DONE; a new batch starts at the following IDLE cycle.
- Reset mid-batch:
  - Setup: full batch; drive rst low in the 2nd ISSUE cycle for 1 cycle.
  - Required response: stall and ram_we drop immediately; no done pulse; rd_data all 0; next request behaves as in the single-read case.
